data_bus: RTL and testbench

Data-side memory subsystem directly downstream of the core's load/store port. It decodes `mem_addr` into a word-addressed data RAM and a memory-mapped UART transmitter with a small TX FIFO, and returns registered read data on `mem_rdata`. Instruction fetch stays on the separate ROM port; this block serves data accesses only.

---
 rtl/data_bus.sv | 170 +++++++++++++++++
 tb/tb_data_bus.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus.sv
// data_bus: data-side RAM plus a memory-mapped UART transmitter with a TX FIFO.
// Define DATA_BUS_UART_EN to build the UART, FIFO and STATUS register; otherwise only RAM is decoded.
module data_bus #(
   parameter int unsigned RAM_WORDS  = 1024,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned BAUD_DIV   = 868,
   parameter logic [31:0] UART_BASE  = 32'h1000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] mem_addr,
   input  logic        mem_r_enable,
   input  logic        mem_w_enable,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        uart_tx
);

   localparam int unsigned AW = $clog2(RAM_WORDS);

   logic [31:0]   ram [RAM_WORDS];
   logic          ram_sel;
   logic [AW-1:0] ram_idx;
   logic [31:0]   rd_next;

   assign ram_sel = (mem_addr[31:28] == 4'h0);
   assign ram_idx = mem_addr[AW+1:2];

   // RAM is read combinationally, so a same-cycle write is seen only by the next read.
   always_ff @(posedge clk) begin
      if (mem_w_enable && ram_sel) ram[ram_idx] <= mem_wdata;
   end

`ifdef DATA_BUS_UART_EN
   localparam int unsigned FW = $clog2(FIFO_DEPTH);
   localparam int unsigned BW = $clog2(BAUD_DIV);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [FW-1:0] wr_ptr;
   logic [FW-1:0] rd_ptr;
   logic [FW:0]   count;
   logic          overflow;
   logic [BW-1:0] baud_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          tx;
   logic          tx_sel;
   logic          status_sel;
   logic          full;
   logic          push_req;
   logic          push;
   logic          pop;
   logic          status_rd;
   logic [31:0]   count_ext;
   logic [31:0]   status;

   assign tx_sel     = (mem_addr == UART_BASE);
   assign status_sel = (mem_addr == UART_BASE + 32'd4);
   assign full       = (count == (FW+1)'(FIFO_DEPTH));
   assign push_req   = mem_w_enable && tx_sel;
   assign push       = push_req && !full;
   assign pop        = (state == IDLE) && (count != '0);
   assign status_rd  = mem_r_enable && status_sel;
   assign count_ext  = 32'(count);
   assign status     = {24'h0, count_ext[3:0], 1'b0, overflow, full, (state != IDLE)};

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= mem_wdata[7:0];
   end

   // Full is judged before the same-cycle pop; a set of overflow wins over a STATUS-read clear.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + FW'(1);
         if (pop)  rd_ptr <= rd_ptr + FW'(1);
         case ({push, pop})
            2'b10:   count <= count + (FW+1)'(1);
            2'b01:   count <= count - (FW+1)'(1);
            default: count <= count;
         endcase
         if (push_req && full) overflow <= 1'b1;
         else if (status_rd)   overflow <= 1'b0;
      end
   end

   // 8N1 transmitter; tx is registered alongside each state change so the line follows the state.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         tx       <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  shift    <= fifo_mem[rd_ptr];
                  baud_cnt <= BW'(BAUD_DIV - 1);
                  tx       <= 1'b0;
                  state    <= START;
               end
            end
            START: begin
               if (baud_cnt == '0) begin
                  baud_cnt <= BW'(BAUD_DIV - 1);
                  bit_cnt  <= '0;
                  tx       <= shift[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt - BW'(1);
               end
            end
            DATA: begin
               if (baud_cnt == '0) begin
                  baud_cnt <= BW'(BAUD_DIV - 1);
                  if (bit_cnt == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     shift   <= shift >> 1;
                     tx      <= shift[1];
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt - BW'(1);
               end
            end
            STOP: begin
               if (baud_cnt == '0) state    <= IDLE;
               else                baud_cnt <= baud_cnt - BW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      rd_next = '0;
      if (ram_sel)         rd_next = ram[ram_idx];
      else if (status_sel) rd_next = status;
   end

   assign uart_tx = tx;
`else
   logic unused_addr;

   assign unused_addr = ^mem_addr;

   always_comb begin
      rd_next = '0;
      if (ram_sel) rd_next = ram[ram_idx];
   end

   assign uart_tx = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n)          mem_rdata <= '0;
      else if (mem_r_enable) mem_rdata <= rd_next;
   end

endmodule

// File: tb/tb_data_bus.sv
// Directed testbench for data_bus (BAUD_DIV=4, FIFO_DEPTH=4); UART scenarios follow DATA_BUS_UART_EN.
`timescale 1ns/1ps
module tb_data_bus;

   localparam int unsigned  BAUD      = 4;
   localparam logic [31:0]  UART_BASE = 32'h1000_0000;
   localparam logic [31:0]  TXDATA    = UART_BASE;
   localparam logic [31:0]  STATUS    = UART_BASE + 32'd4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] mem_addr;
   logic        mem_r_enable;
   logic        mem_w_enable;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        uart_tx;

   int checks = 0;
   int errors = 0;

   data_bus #(
      .RAM_WORDS (1024),
      .FIFO_DEPTH(4),
      .BAUD_DIV  (BAUD),
      .UART_BASE (UART_BASE)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .mem_addr    (mem_addr),
      .mem_r_enable(mem_r_enable),
      .mem_w_enable(mem_w_enable),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .uart_tx     (uart_tx)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      mem_addr     = addr;
      mem_wdata    = data;
      mem_w_enable = 1'b1;
      tick();
      mem_w_enable = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
      mem_addr     = addr;
      mem_r_enable = 1'b1;
      tick();
      mem_r_enable = 1'b0;
      data         = mem_rdata;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      reset_n      = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      mem_r_enable = 1'b0;
      mem_w_enable = 1'b0;
      tick();
      tick();
      checks++;
      if (mem_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_rdata: got %h expected %h", mem_rdata, 32'h0);
      end
      checks++;
      if (uart_tx !== 1'b1) begin
         errors++;
         $display("FAIL reset_tx: got %b expected 1", uart_tx);
      end
      reset_n = 1'b1;
      bus_read(STATUS, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL reset_status: got %h expected %h", d, 32'h0);
      end
   endtask

   task automatic test_ram;
      logic [31:0] d;
      bus_write(32'h0000_0010, 32'hDEAD_BEEF);
      bus_read(32'h0000_0013, d);
      checks++;
      if (d !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL ram_read: got %h expected %h", d, 32'hDEAD_BEEF);
      end
      mem_addr = 32'h0;
      repeat (3) tick();
      checks++;
      if (mem_rdata !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL ram_hold: got %h expected %h", mem_rdata, 32'hDEAD_BEEF);
      end
      // Byte 0x1000 is word 1024, which aliases to word 0 in a 1024-word RAM.
      bus_write(32'h0000_0000, 32'h1111_2222);
      bus_read(32'h0000_1000, d);
      checks++;
      if (d !== 32'h1111_2222) begin
         errors++;
         $display("FAIL ram_alias: got %h expected %h", d, 32'h1111_2222);
      end
   endtask

   task automatic test_read_before_write;
      logic [31:0] d;
      bus_write(32'h0000_0020, 32'd5);
      mem_addr     = 32'h0000_0020;
      mem_wdata    = 32'd9;
      mem_r_enable = 1'b1;
      mem_w_enable = 1'b1;
      tick();
      mem_r_enable = 1'b0;
      mem_w_enable = 1'b0;
      checks++;
      if (mem_rdata !== 32'd5) begin
         errors++;
         $display("FAIL rbw_old: got %h expected %h", mem_rdata, 32'd5);
      end
      bus_read(32'h0000_0020, d);
      checks++;
      if (d !== 32'd9) begin
         errors++;
         $display("FAIL rbw_new: got %h expected %h", d, 32'd9);
      end
   endtask

   task automatic test_unmapped;
      logic [31:0] d;
      bus_read(32'h0000_0000, d);
      bus_read(32'h2000_0000, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL unmapped_read: got %h expected %h", d, 32'h0);
      end
      bus_write(32'h2000_0000, 32'hFFFF_FFFF);
      bus_read(32'h0000_0000, d);
      checks++;
      if (d !== 32'h1111_2222) begin
         errors++;
         $display("FAIL unmapped_write: got %h expected %h", d, 32'h1111_2222);
      end
      bus_read(TXDATA, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL txdata_read: got %h expected %h", d, 32'h0);
      end
   endtask

`ifdef DATA_BUS_UART_EN
   task automatic test_uart_frame;
      logic [9:0]  frame;
      logic        exp;
      logic [31:0] d;
      frame = {1'b1, 8'h55, 1'b0};
      bus_write(TXDATA, 32'h55);
      checks++;
      if (uart_tx !== 1'b1) begin
         errors++;
         $display("FAIL frame_pre_start: got %b expected 1", uart_tx);
      end
      tick();
      for (int k = 0; k < 40; k++) begin
         exp = frame[k / 4];
         checks++;
         if (uart_tx !== exp) begin
            errors++;
            $display("FAIL frame_bit k=%0d: got %b expected %b", k, uart_tx, exp);
         end
         if (k == 10) begin
            mem_addr     = STATUS;
            mem_r_enable = 1'b1;
         end else begin
            mem_r_enable = 1'b0;
         end
         if (k == 11) begin
            checks++;
            if (mem_rdata !== 32'h1) begin
               errors++;
               $display("FAIL frame_status_busy: got %h expected %h", mem_rdata, 32'h1);
            end
         end
         tick();
      end
      checks++;
      if (uart_tx !== 1'b1) begin
         errors++;
         $display("FAIL frame_idle: got %b expected 1", uart_tx);
      end
      bus_read(STATUS, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL frame_status_done: got %h expected %h", d, 32'h0);
      end
   endtask

   task automatic test_overflow;
      logic [7:0] bytes [6];
      logic [7:0] rx;
      int         frames;
      bit         in_frame;
      int         pos;
      bytes    = '{8'hA1, 8'h3C, 8'h0F, 8'hF0, 8'h96, 8'h77};
      frames   = 0;
      in_frame = 1'b0;
      pos      = 0;
      rx       = '0;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               mem_addr     = TXDATA;
               mem_wdata    = {24'h0, bytes[i]};
               mem_w_enable = 1'b1;
               tick();
            end
            mem_w_enable = 1'b0;
            mem_addr     = STATUS;
            mem_r_enable = 1'b1;
            tick();
            // count=4, overflow, full, and busy with the first byte's frame
            checks++;
            if (mem_rdata !== 32'h47) begin
               errors++;
               $display("FAIL ovf_status1: got %h expected %h", mem_rdata, 32'h47);
            end
            tick();
            mem_r_enable = 1'b0;
            checks++;
            if (mem_rdata !== 32'h43) begin
               errors++;
               $display("FAIL ovf_status2: got %h expected %h", mem_rdata, 32'h43);
            end
         end
         begin
            for (int c = 0; c < 260; c++) begin
               tick();
               if (!in_frame) begin
                  if (uart_tx === 1'b0) begin
                     in_frame = 1'b1;
                     pos      = 0;
                     frames++;
                  end
               end else begin
                  pos++;
                  if (pos >= 6 && pos <= 34 && ((pos - 6) % 4) == 0) rx[(pos - 6) / 4] = uart_tx;
                  if (pos == 38) begin
                     checks++;
                     if (uart_tx !== 1'b1 || frames > 6 || rx !== bytes[(frames - 1) % 6]) begin
                        errors++;
                        $display("FAIL ovf_frame%0d: got %h stop %b expected %h", frames, rx, uart_tx,
                                 bytes[(frames - 1) % 6]);
                     end
                  end
                  if (pos == 39) in_frame = 1'b0;
               end
            end
         end
      join
      checks++;
      if (frames !== 5) begin
         errors++;
         $display("FAIL ovf_frame_count: got %0d expected 5", frames);
      end
   endtask

   task automatic test_reset_mid_frame;
      logic [31:0] d;
      int          zeros;
      bus_write(TXDATA, 32'hC3);
      bus_write(TXDATA, 32'h3C);
      repeat (10) tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      checks++;
      if (uart_tx !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_tx: got %b expected 1", uart_tx);
      end
      checks++;
      if (mem_rdata !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid_rdata: got %h expected %h", mem_rdata, 32'h0);
      end
      bus_read(STATUS, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid_status: got %h expected %h", d, 32'h0);
      end
      zeros = 0;
      repeat (60) begin
         tick();
         if (uart_tx !== 1'b1) zeros++;
      end
      checks++;
      if (zeros !== 0) begin
         errors++;
         $display("FAIL rst_mid_quiet: got %0d low cycles expected 0", zeros);
      end
      bus_read(32'h0000_0010, d);
      checks++;
      if (d !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL rst_mid_ram: got %h expected %h", d, 32'hDEAD_BEEF);
      end
   endtask
`else
   task automatic test_uart_disabled;
      logic [31:0] d;
      int          zeros;
      bus_read(32'h0000_0010, d);
      bus_write(TXDATA, 32'h55);
      zeros = 0;
      repeat (60) begin
         tick();
         if (uart_tx !== 1'b1) zeros++;
      end
      checks++;
      if (zeros !== 0) begin
         errors++;
         $display("FAIL off_tx_quiet: got %0d low cycles expected 0", zeros);
      end
      bus_read(STATUS, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL off_status: got %h expected %h", d, 32'h0);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_ram();
      test_read_before_write();
      test_unmapped();
`ifdef DATA_BUS_UART_EN
      test_uart_frame();
      test_overflow();
      test_reset_mid_frame();
`else
      test_uart_disabled();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog timeout");
   end

endmodule
